// File: rtl/ysyx_24070016_fetch_pkg.sv
// Shared types for the instruction-fetch controller: FSM states and the
// {pc, inst} entry carried from memory toward IDU.
package ysyx_24070016_fetch_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } fetch_state_e;

   localparam int FETCH_XLEN = 32;

   // Entry layout for the default 32-bit configuration; the FIFO stores it packed.
   typedef struct packed {
      logic [FETCH_XLEN-1:0] pc;
      logic [FETCH_XLEN-1:0] inst;
   } fetch_entry_t;

endpackage

// File: rtl/ysyx_24070016_Reg.sv
// Generic enable-gated register with a configurable reset value.
module ysyx_24070016_Reg #(
   parameter int               WIDTH     = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   input  logic             wen
);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)      dout <= RESET_VAL;
      else if (wen) dout <= din;
   end

endmodule

// File: rtl/ysyx_24070016_fetch_fifo.sv
// Synchronous first-word-fall-through FIFO with push, pop, flush and occupancy count.
module ysyx_24070016_fetch_fifo #(
   parameter int  WIDTH = 64,
   parameter int  DEPTH = 2,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic             i_flush,
   input  logic [WIDTH-1:0] i_data,
   output logic [WIDTH-1:0] o_data,
   output logic             o_empty,
   output logic [CNT_W-1:0] o_count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_do_push;
   logic             w_do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign o_empty   = (r_count == '0);
   assign o_count   = r_count;
   assign o_data    = r_mem[r_rd_ptr];
   assign w_do_pop  = i_pop && !o_empty;
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign w_do_push = i_push && ((r_count != CNT_W'(DEPTH)) || w_do_pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
         if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
         if (w_do_push && !w_do_pop)      r_count <= r_count + CNT_W'(1);
         else if (w_do_pop && !w_do_push) r_count <= r_count - CNT_W'(1);
      end
   end

   // NOTE: storage is not reset; the count alone decides which slots hold valid data.
   always_ff @(posedge clk) begin
      if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
   end

endmodule

// File: rtl/ysyx_24070016_fetch_ctrl.sv
// Multi-cycle fetch controller: owns the PC, issues one outstanding request at a
// time, buffers {pc, inst} toward IDU and flushes stale work on redirect.
module ysyx_24070016_fetch_ctrl
   import ysyx_24070016_fetch_pkg::*;
#(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DATA_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h8000_0000,
   parameter int                    PC_STEP    = 4,
   parameter int                    FIFO_DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  inst_mem_req_valid,
   input  logic                  inst_mem_req_ready,
   output logic [ADDR_WIDTH-1:0] inst_mem_addr,
   output logic                  inst_mem_wen,
   output logic [DATA_WIDTH-1:0] inst_mem_wdata,
   input  logic                  inst_mem_rsp_valid,
   input  logic [DATA_WIDTH-1:0] inst_mem_rdata,
   output logic                  inst_valid,
   input  logic                  inst_ready,
   output logic [DATA_WIDTH-1:0] inst,
   output logic [ADDR_WIDTH-1:0] inst_pc,
   input  logic                  redirect_valid,
   input  logic [ADDR_WIDTH-1:0] redirect_pc
);

   localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
   localparam int ENTRY_W = ADDR_WIDTH + DATA_WIDTH;

   fetch_state_e          r_state;
   fetch_state_e          w_state_next;
   logic                  r_discard;
   logic                  w_discard_next;
   logic [ADDR_WIDTH-1:0] r_req_pc;
   logic [ADDR_WIDTH-1:0] w_pc;
   logic [ADDR_WIDTH-1:0] w_pc_next;
   logic                  w_hs;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_fifo_empty;
   logic [CNT_W-1:0]      w_fifo_count;
   logic [ENTRY_W-1:0]    w_head;

   assign inst_mem_wen       = 1'b0;
   assign inst_mem_wdata     = '0;
   assign inst_mem_addr      = w_pc;
   assign inst_mem_req_valid = (r_state == REQ) && (w_fifo_count < CNT_W'(FIFO_DEPTH));
   assign w_hs               = inst_mem_req_valid && inst_mem_req_ready;

   // A redirect overrides the sequential step, even when it lands on a handshake.
   assign w_pc_next = redirect_valid ? redirect_pc : w_pc + ADDR_WIDTH'(PC_STEP);

   ysyx_24070016_Reg #(
      .WIDTH     (ADDR_WIDTH),
      .RESET_VAL (RESET_PC)
   ) u_pc_reg (
      .clk  (clk),
      .rst  (rst),
      .din  (w_pc_next),
      .dout (w_pc),
      .wen  (w_hs || redirect_valid)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_discard <= 1'b0;
         r_req_pc  <= '0;
      end else begin
         r_state   <= w_state_next;
         r_discard <= w_discard_next;
         if (w_hs) r_req_pc <= w_pc;
      end
   end

   // NOTE: every combinational output gets a default first so no path infers a latch.
   always_comb begin
      w_state_next   = r_state;
      w_discard_next = r_discard;
      w_push         = 1'b0;
      unique case (r_state)
         IDLE: w_state_next = REQ;
         REQ: begin
            if (w_hs) begin
               w_state_next   = WAIT;
               w_discard_next = redirect_valid;
            end
         end
         WAIT: begin
            if (inst_mem_rsp_valid) begin
               w_push         = !r_discard && !redirect_valid;
               w_discard_next = 1'b0;
               w_state_next   = REQ;
            end else if (redirect_valid) begin
               w_discard_next = 1'b1;
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   assign w_pop = inst_valid && inst_ready;

   ysyx_24070016_fetch_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_flush (redirect_valid),
      .i_data  ({r_req_pc, inst_mem_rdata}),
      .o_data  (w_head),
      .o_empty (w_fifo_empty),
      .o_count (w_fifo_count)
   );

   // Head fields are masked while empty so unwritten storage never leaks out.
   assign inst_valid = !w_fifo_empty;
   assign inst       = inst_valid ? w_head[DATA_WIDTH-1:0]       : '0;
   assign inst_pc    = inst_valid ? w_head[ENTRY_W-1:DATA_WIDTH] : '0;

endmodule
